// File: rtl/muldiv.sv
// ---------------------------------------------------------------------------
// muldiv: iterative 32-bit multiply / divide unit with HI/LO result registers.
//
// An accepted start latches operand magnitudes. The unit then runs 32
// shift-add (multiply) or restoring-divide iterations, one per clock. A final
// cycle applies sign correction and writes HI/LO. That gives 33 clocks from
// the start edge to the HI/LO update; done pulses in the cycle after.
//
// Build option:
//   MULDIV_DIV_EN  when defined, DIV/DIVU are implemented. When undefined, the
//                  divider datapath is omitted and a start with op[1]=1 is
//                  ignored.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   start        operation request, sampled only when idle
//   op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a[31:0]      multiplicand / dividend
//   b[31:0]      multiplier / divisor
//   hi_wr/lo_wr  write wd into HI/LO while idle (dropped if start is accepted)
//   wd[31:0]     write data for hi_wr/lo_wr
//   busy         high while an operation is in flight
//   done         one-cycle pulse after HI/LO take a new result
//   hi/lo[31:0]  registered HI/LO results
// ---------------------------------------------------------------------------
module muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t      state_r, state_s;
  logic        accept_s, load_s, iter_s, fix_s, wr_ok_s;
  logic [4:0]  cnt_r;
  logic [63:0] acc_r;       // multiply: running product; divide: remainder in [63:32]
  logic [31:0] opa_r;       // multiplicand, or dividend shifting into quotient
  logic [31:0] opb_r;       // multiplier (shifts right), or divisor
  logic        neg_r;       // product / quotient must be negated at the end
  logic [32:0] mul_sum_s;
  logic [63:0] prod_s;
  logic [31:0] res_hi_s, res_lo_s;
`ifdef MULDIV_DIV_EN
  logic        is_div_r;
  logic        rem_neg_r;   // remainder takes the sign of the dividend
  logic        div_zero_r;
  logic [32:0] trial_s, diff_s;
  logic        qbit_s;
`endif

  // Magnitude of x when it is a signed operand, otherwise x unchanged.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    if (sgn && x[31]) mag32 = 32'd0 - x;
    else              mag32 = x;
  endfunction

  // Start acceptance: divide requests are dropped when the divider is not built
  always_comb begin
`ifdef MULDIV_DIV_EN
    accept_s = start;
`else
    accept_s = start & ~op[1];
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = RUN; else state_s = IDLE;
      RUN:     if (cnt_r == 5'd31) state_s = FIX; else state_s = RUN;
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control decode per state
  always_comb begin
    load_s  = 1'b0;
    iter_s  = 1'b0;
    fix_s   = 1'b0;
    wr_ok_s = 1'b0;
    case (state_r)
      IDLE: begin
        load_s  = accept_s;
        wr_ok_s = ~accept_s;   // an accepted start wins over MTHI/MTLO
      end
      RUN:     iter_s = 1'b1;
      FIX:     fix_s  = 1'b1;
      default: load_s = 1'b0;
    endcase
  end

  // Iteration arithmetic
  always_comb begin
    mul_sum_s = {1'b0, acc_r[63:32]} + (opb_r[0] ? {1'b0, opa_r} : 33'd0);
`ifdef MULDIV_DIV_EN
    trial_s = {acc_r[63:32], opa_r[31]};
    diff_s  = trial_s - {1'b0, opb_r};
    qbit_s  = ~diff_s[32];     // no borrow: divisor fits into the trial remainder
`endif
  end

  // Operand latch and per-cycle iteration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= 5'd0;
      acc_r      <= 64'd0;
      opa_r      <= 32'd0;
      opb_r      <= 32'd0;
      neg_r      <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_r   <= 1'b0;
      rem_neg_r  <= 1'b0;
      div_zero_r <= 1'b0;
`endif
    end else if (load_s) begin
      cnt_r      <= 5'd0;
      acc_r      <= 64'd0;
      opa_r      <= mag32(a, ~op[0]);
      opb_r      <= mag32(b, ~op[0]);
      neg_r      <= ~op[0] & (a[31] ^ b[31]);
`ifdef MULDIV_DIV_EN
      is_div_r   <= op[1];
      rem_neg_r  <= ~op[0] & a[31];
      div_zero_r <= (b == 32'd0);
`endif
    end else if (iter_s) begin
      cnt_r <= cnt_r + 5'd1;
`ifdef MULDIV_DIV_EN
      if (is_div_r) begin
        acc_r[63:32] <= qbit_s ? diff_s[31:0] : trial_s[31:0];
        opa_r        <= {opa_r[30:0], qbit_s};
      end else begin
        acc_r <= {mul_sum_s, acc_r[31:1]};
        opb_r <= {1'b0, opb_r[31:1]};
      end
`else
      acc_r <= {mul_sum_s, acc_r[31:1]};
      opb_r <= {1'b0, opb_r[31:1]};
`endif
    end
  end

  // Sign correction of the finished result
  always_comb begin
    prod_s   = neg_r ? (64'd0 - acc_r) : acc_r;
    res_hi_s = prod_s[63:32];
    res_lo_s = prod_s[31:0];
`ifdef MULDIV_DIV_EN
    if (is_div_r) begin
      // divide by zero: quotient all ones, remainder equals the raw dividend
      res_lo_s = div_zero_r ? 32'hFFFF_FFFF : (neg_r ? (32'd0 - opa_r) : opa_r);
      res_hi_s = rem_neg_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
    end else begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end
`endif
  end

  // Registered outputs: HI/LO, busy, done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      done <= fix_s;
      if (fix_s) begin
        hi <= res_hi_s;
        lo <= res_lo_s;
      end else if (wr_ok_s) begin
        if (hi_wr) hi <= wd;
        if (lo_wr) lo <= wd;
      end
    end
  end

endmodule

// File: tb/tb_muldiv.sv
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wd = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI,LO} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sq, sr;
    case (o)
      2'b00: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return sp;
      end
      2'b01: begin
        up = {32'd0, x} * {32'd0, y};
        return up;
      end
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Behavioural model: an accepted op completes 33 edges later.
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic        m_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
        end
      end else if (start && (DIV_EN || !op[1])) begin
        {p_hi, p_lo} <= ref_result(op, a, b);
        m_left       <= 33;
      end else begin
        if (hi_wr) m_hi <= wd;
        if (lo_wr) m_lo <= wd;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check32("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    check32("done", {31'd0, done}, {31'd0, m_done});
    check32("hi", hi, m_hi);
    check32("lo", lo, m_lo);
  end

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  // Wait (bounded) for done, counting busy cycles on the way.
  task automatic wait_done(output int bc);
    bit ok;
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (done) ok = 1'b1;
      else begin
        if (busy) bc++;
        @(negedge clk);
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout: done not seen within 50 cycles, got 0 expected 1");
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [63:0] r;
  int          bc;

  initial begin
    // Pin the reference model with hand-computed results.
    r = ref_result(2'b00, 32'hFFFF_FFFE, 32'd3);
    check32("pin_mult_hi", r[63:32], 32'hFFFF_FFFF);
    check32("pin_mult_lo", r[31:0], 32'hFFFF_FFFA);
    r = ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check32("pin_multu_hi", r[63:32], 32'hFFFF_FFFE);
    check32("pin_multu_lo", r[31:0], 32'h0000_0001);
    r = ref_result(2'b10, 32'hFFFF_FFF9, 32'd2);
    check32("pin_div_lo", r[31:0], 32'hFFFF_FFFD);
    check32("pin_div_hi", r[63:32], 32'hFFFF_FFFF);
    r = ref_result(2'b11, 32'd7, 32'd0);
    check32("pin_divu0_lo", r[31:0], 32'hFFFF_FFFF);
    check32("pin_divu0_hi", r[63:32], 32'd7);

    // Reset state
    repeat (3) @(negedge clk);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);

    // First start accepted on the first edge with reset released: MULT -2 * 3
    rst = 1'b1;
    start_op(2'b00, 32'hFFFF_FFFE, 32'd3);
    wait_done(bc);
    check32("mult_busy_cycles", bc, 32'd33);
    check32("mult_hi", hi, 32'hFFFF_FFFF);
    check32("mult_lo", lo, 32'hFFFF_FFFA);
    @(negedge clk);
    check32("mult_done_once", {31'd0, done}, 32'd0);

    // MULTU all ones
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    check32("multu_hi", hi, 32'hFFFF_FFFE);
    check32("multu_lo", lo, 32'h0000_0001);

    if (DIV_EN) begin
      start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_done(bc);
      check32("div_lo", lo, 32'hFFFF_FFFD);
      check32("div_hi", hi, 32'hFFFF_FFFF);
      start_op(2'b11, 32'd7, 32'd0);
      wait_done(bc);
      check32("divu0_busy_cycles", bc, 32'd33);
      check32("divu0_lo", lo, 32'hFFFF_FFFF);
      check32("divu0_hi", hi, 32'd7);
      start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(bc);
      check32("div_ovf_lo", lo, 32'h8000_0000);
      check32("div_ovf_hi", hi, 32'd0);
    end else begin
      // Divide request ignored in a multiply-only build
      start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      for (int i = 0; i < 40; i++) begin
        check32("nodiv_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
      end
      check32("nodiv_hi", hi, 32'hFFFF_FFFE);
      check32("nodiv_lo", lo, 32'h0000_0001);
    end

    // Second start and MTHI mid-RUN have no effect
    start_op(2'b01, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd200; hi_wr = 1'b1; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0;
    wait_done(bc);
    check32("ignore_hi", hi, 32'd0);
    check32("ignore_lo", lo, 32'd30);

    // Start and MTLO in the same idle cycle: start wins
    @(negedge clk);
    lo_wr = 1'b1; wd = 32'h5555_5555;
    start_op(2'b01, 32'd3, 32'd4);
    lo_wr = 1'b0;
    wait_done(bc);
    check32("start_wins_lo", lo, 32'd12);

    // Reset mid-RUN aborts the operation
    start_op(2'b00, 32'd9, 32'd9);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    lo_wr = 1'b1; wd = 32'h0000_1234;
    @(negedge clk);
    lo_wr = 1'b0;
    check32("mtlo_after_abort", lo, 32'h0000_1234);

    // Randomized traffic checked by the compare process
    for (int n = 0; n < 6000; n++) begin
      start = ($urandom_range(0, 5) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
      hi_wr = ($urandom_range(0, 7) == 0);
      lo_wr = ($urandom_range(0, 7) == 0);
      wd    = $urandom;
      if ($urandom_range(0, 799) == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameters: none; operand and result widths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  operand A (register-file rda): multiplicand or dividend.
REQ-007 b  input  32  operand B (register-file rdb): multiplier or divisor.
REQ-008 hi_wr  input  1  MTHI strobe: write wd to HI.
REQ-009 lo_wr  input  1  MTLO strobe: write wd to LO.
REQ-010 wd  input  32  write data for hi_wr/lo_wr.
REQ-011 busy  output  1  high while an operation is in flight (RUN or FIX).
REQ-012 done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-013 hi  output  32  HI register; registered output.
REQ-014 lo  output  32  LO register; registered output.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and FIX.
REQ-016 IDLE with start=1 at an edge: the block SHALL latch |a| and |b| (raw a and b for unsigned ops) and the op and sign bits; clear the accumulator and the 5-bit counter; go to RUN.
REQ-017 RUN: each edge SHALL perform one iteration, either shift-add multiply or restoring divide (one quotient bit); after iteration 31 (counter=31) go to FIX.
REQ-018 FIX: one edge SHALL apply sign correction, write HI/LO, pulse done for exactly one cycle, and return to IDLE.
REQ-019 Latency SHALL be 33 clocks from the start-sampling edge to the edge that updates HI/LO; done SHALL be high in the cycle following that edge.
REQ-020 busy SHALL be 1 from the edge after start is sampled until the FIX edge; it SHALL be 0 in the done cycle.
REQ-021 MULT/MULTU: {HI,LO} SHALL equal the 64-bit product, two's complement for MULT.
REQ-022 DIV/DIVU: LO SHALL be the quotient and HI the remainder; for DIV the quotient sign is sign(a)^sign(b) and the remainder sign equals sign(a) (truncating division).
REQ-023 DIV with a=0x80000000 and b=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-024 Divide by zero (b=0) SHALL take the same latency and give LO=0xFFFFFFFF and HI=a.
REQ-025 start while busy SHALL be ignored with no queueing.
REQ-026 hi_wr/lo_wr in IDLE SHALL write wd on that edge; when busy they SHALL be ignored.
REQ-027 start and hi_wr/lo_wr in the same IDLE cycle: start SHALL win and the writes are dropped.
REQ-028 Operands a/b SHALL be sampled only at the start edge; later changes have no effect.

Reset
REQ-029 With rst=0, asynchronously: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0, accumulator=0.
REQ-030 Reset during RUN/FIX SHALL abort the operation; no done pulse and no HI/LO update after release.
REQ-031 The first start SHALL be accepted on the first edge with rst=1.

Configuration
REQ-032 Macro MULDIV_DIV_EN: when defined, DIV/DIVU SHALL be implemented as specified.
REQ-033 Without MULDIV_DIV_EN: start with op[1]=1 SHALL be ignored (busy stays 0, no done, HI/LO unchanged); divider logic SHALL be absent; multiply behaviour SHALL be unchanged.

Verification
REQ-034 MULT a=0xFFFFFFFE (-2), b=3 -> after 33 clocks hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once; busy high for 33 cycles.
REQ-035 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-037 start MULTU 5x6, reassert start mid-RUN with other operands, and pulse hi_wr mid-RUN -> result hi=0, lo=30; the second start and the write have no effect.
REQ-038 rst=0 at RUN cycle 10 -> hi=lo=0, busy=0 immediately, no done; then lo_wr with wd=0x1234 -> lo=0x1234.
REQ-039 Build without MULDIV_DIV_EN: start DIV -> busy stays 0 for 40 cycles and HI/LO unchanged; MULT still correct.
